phase_a_sched: RTL and testbench
================================

# phase_a_sched

Two-requester scheduler that time-shares one `phase_a` Montgomery-digit reduction datapath. It arbitrates round-robin between requesters and latches the winner's operand. It then issues `phase_a` rounds back-to-back, feeding each `new_a` back zero-extended, so a job of N rounds returns a·2^(−radix·N) mod m. It sits between the exponentiation control and the single `phase_a` instance.

## Interface
- Size, 3072, modulus width
- radix, 78, digit width per round
- RW, 6, round-count width
- TIMEOUT, 64, cycle limit per round (used only with the macro)
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- req0_valid / req1_valid  in  1  job request
- req0_ready / req1_ready  out  1  job accepted when valid&ready
- req0_a / req1_a  in  Size+radix+1  initial operand
- req0_rounds / req1_rounds  in  RW  number of rounds N
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_id  out  1  requester index of result
- res_data  out  Size  final operand
- res_err  out  1  round timed out (0 without macro)
- busy  out  1  FSM not in IDLE
- pa_en  out  1  `phase_a` start pulse
- pa_a  out  Size+radix+1  `phase_a` operand
- pa_new_a  in  Size  `phase_a` result
- pa_en_out  in  1  `phase_a` result-valid strobe

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE: exactly one req_ready high, for the arbiter winner among valid requesters. On handshake, latch operand into acc (Size+radix+1), rounds into rem, and winner into id. Go to ISSUE if rounds≠0, else DONE.
- Round-robin: pointer `last` is reset to 1, so req0 wins the first contest. If both are valid, grant ≠last. A single valid requester is always granted. `last` updates on each handshake.
- ISSUE: pa_en=1 for exactly one cycle; pa_a=acc is held constant from ISSUE through WAIT. Go to WAIT.
- WAIT: on pa_en_out=1, acc←{(radix+1)'b0, pa_new_a} and rem←rem−1. Go to NEXT.
- NEXT: go to ISSUE if rem≠0, else DONE. The NEXT cycle guarantees pa_en is low for at least two cycles between pulses, as the `phase_a` edge detector requires.
- DONE: res_valid=1, res_data=acc[Size-1:0], res_id=id. These are stable until res_ready. On res_valid&res_ready go to IDLE.
- rounds=0: no pa_en activity; result is the low Size bits of the operand, reached one cycle after the handshake.
- pa_en_out outside WAIT is ignored.
- A requester may drop valid before ready with no effect. No new job is accepted before the result handshake.
- Reset, including mid-job: state=IDLE, `last`=1. Outputs are zero: pa_en, pa_a, res_valid, res_data, res_id, res_err, busy, req*_ready. Any in-flight round is abandoned. The top level drives `phase_a` rst_n=~rst.

## Timing
- Accept → first pa_en: 1 cycle.
- Per round: 1 (ISSUE) + L_pa (pa_en to pa_en_out) + 1 (NEXT) cycles.
- Last capture → res_valid: 2 cycles.
- res_valid may stay high indefinitely. res_ready while res_valid is low has no effect.
- All outputs are registered, except req*_ready, which is combinational from state, valids and `last`.

## Configuration
- PHASE_A_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT. When it reaches TIMEOUT with no pa_en_out, go to DONE with res_err=1 and res_data=acc at that moment.
  - The counter clears on entry to ISSUE.
- Undefined: no counter, and res_err is tied 0. WAIT waits forever.

## Structure
- Package `phase_a_pkg`: SIZE, RADIX, RW, TIMEOUT defaults and the state enum `sched_state_t`.
- Sub-module `rr_arb2`: 2-way round-robin grant logic holding the `last` pointer, with update on handshake.

## Test plan
- Single job, req0 rounds=3, stub L_pa=5: three pa_en pulses 7 cycles apart. res_data equals the model of a·2^(−234) mod m, and res_id=0.
- Both valid in the same cycle after reset: req0 is granted first and req1 second. Repeating the scenario alternates the winner.
- rounds=0 with a=operand: no pa_en. res_valid appears 1 cycle after accept with res_data=a[3071:0].
- Hold res_ready=0 for 20 cycles: result stable, req*_ready low, then accept on release.
- Assert rst during WAIT of round 2: all outputs 0 the next cycle, and a following job completes correctly.
- With PHASE_A_SCHED_TIMEOUT_EN and a stub that never returns: res_err=1 with res_valid exactly TIMEOUT cycles after WAIT entry.

Source files
------------

// File: rtl/phase_a_pkg.sv
// Shared sizing defaults and FSM state encoding for the phase_a round scheduler.
package phase_a_pkg;
  localparam int SIZE    = 3072;
  localparam int RADIX   = 78;
  localparam int RW      = 6;
  localparam int TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } sched_state_t;
endpackage

// File: rtl/phase_a_sched_rr_arb2.sv
// Two-way round-robin grant; the last pointer moves to whichever requester was just granted.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);
  logic last_q, last_d;

  // A lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    gnt0_o = en_i & req0_i & (~req1_i | last_q);
    gnt1_o = en_i & req1_i & (~req0_i | ~last_q);
    last_d = last_q;
    if (gnt0_o | gnt1_o) last_d = gnt1_o;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/phase_a_sched.sv
// Time-shares one phase_a datapath between two requesters, chaining N rounds per job.
// Optional per-round watchdog: define PHASE_A_SCHED_TIMEOUT_EN.
module phase_a_sched
  import phase_a_pkg::*;
#(
  parameter int Size    = SIZE,
  parameter int radix   = RADIX,
  parameter int RW      = phase_a_pkg::RW,
  parameter int TIMEOUT = phase_a_pkg::TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [Size+radix:0]   req0_a,
  input  logic [Size+radix:0]   req1_a,
  input  logic [RW-1:0]         req0_rounds,
  input  logic [RW-1:0]         req1_rounds,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_id,
  output logic [Size-1:0]       res_data,
  output logic                  res_err,
  output logic                  busy,
  output logic                  pa_en,
  output logic [Size+radix:0]   pa_a,
  input  logic [Size-1:0]       pa_new_a,
  input  logic                  pa_en_out
);
  localparam int AW = Size + radix + 1;

  sched_state_t  state_q;
  logic [AW-1:0] acc_q;
  logic [RW-1:0] rem_q;
  logic          id_q, pa_en_q, res_valid_q, busy_q;
  logic          gnt0, gnt1, hs;
  logic [AW-1:0] win_a;
  logic [RW-1:0] win_n;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en_i   ((state_q == S_IDLE) && !rst),
    .req0_i (req0_valid),
    .req1_i (req1_valid),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs         = gnt0 | gnt1;
  assign win_a      = gnt1 ? req1_a : req0_a;
  assign win_n      = gnt1 ? req1_rounds : req0_rounds;

`ifdef PHASE_A_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic          res_err_q;
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      id_q        <= 1'b0;
      pa_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
      tcnt_q      <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: if (hs) begin
          acc_q  <= win_a;
          rem_q  <= win_n;
          id_q   <= gnt1;
          busy_q <= 1'b1;
          if (win_n != '0) begin
            state_q <= S_ISSUE;
            pa_en_q <= 1'b1;
          end else begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          pa_en_q <= 1'b0;
          state_q <= S_WAIT;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
          tcnt_q  <= '0;
`endif
        end
        S_WAIT: begin
          if (pa_en_out) begin
            acc_q   <= {{(radix+1){1'b0}}, pa_new_a};
            rem_q   <= rem_q - 1'b1;
            state_q <= S_NEXT;
          end
`ifdef PHASE_A_SCHED_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
`endif
        end
        // Extra gap cycle keeps pa_en low long enough for phase_a's edge detector.
        S_NEXT: begin
          if (rem_q != '0) begin
            state_q <= S_ISSUE;
            pa_en_q <= 1'b1;
          end else begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
          end
        end
        S_DONE: if (res_ready) begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
          res_err_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pa_en     = pa_en_q;
  assign pa_a      = acc_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q[Size-1:0];
  assign res_id    = id_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_phase_a_sched.sv
// Bench for phase_a_sched: Montgomery-digit phase_a stub with fixed latency, round-robin and result model.
module tb_phase_a_sched;
  import phase_a_pkg::*;

  localparam int AW  = SIZE + RADIX + 1;
  localparam int TW  = AW + RADIX + 2;
  localparam int CW  = 4096;
  localparam int LPA = 5;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0]   req0_a, req1_a, pa_a;
  logic [RW-1:0]   req0_rounds, req1_rounds;
  logic            res_valid, res_ready, res_id, res_err, busy, pa_en, pa_en_out;
  logic [SIZE-1:0] res_data, pa_new_a;

  phase_a_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a),
    .req0_rounds(req0_rounds), .req1_rounds(req1_rounds),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_err(res_err), .busy(busy),
    .pa_en(pa_en), .pa_a(pa_a), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_last  = 1;
  bit stub_dead = 1'b0;
  int pulses[$];
  logic [SIZE-1:0]  m;
  logic [RADIX-1:0] minv;

  always @(posedge clk) cyc <= cyc + 1;

  // One phase_a digit reduction: (a + q*m) / 2^radix with q making the low digit vanish.
  function automatic logic [SIZE-1:0] reduce(input logic [AW-1:0] a);
    logic [RADIX-1:0] na, q;
    logic [TW-1:0]    t;
    na = -a[RADIX-1:0];
    q  = na * minv;
    t  = TW'(a) + TW'(q) * TW'(m);
    return t[RADIX +: SIZE];
  endfunction

  function automatic logic [SIZE-1:0] expect_res(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] x;
    x = a;
    for (int i = 0; i < n; i++) x = AW'(reduce(x));
    return x[SIZE-1:0];
  endfunction

  // r * 2^(radix*n) == a (mod m)
  function automatic bit congruent(input logic [SIZE-1:0] r, input logic [AW-1:0] a, input int n);
    logic [CW-1:0] lhs, aw, mw;
    lhs = CW'(r) << (RADIX * n);
    aw  = CW'(a);
    mw  = CW'(m);
    return (lhs % mw) == (aw % mw);
  endfunction

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < SIZE + RADIX - 2; i++) a[i] = 1'($urandom_range(0, 1));
    return a;
  endfunction

  // phase_a stub: result strobe LPA cycles after the pa_en rising edge.
  logic       pa_en_d = 1'b0;
  int         scnt = 0;
  logic [AW-1:0] sin;
  always @(posedge clk) begin
    pa_en_d   <= pa_en;
    pa_en_out <= 1'b0;
    if (rst) scnt <= 0;
    else if (pa_en && !pa_en_d && !stub_dead) begin
      scnt <= LPA - 1;
      sin  <= pa_a;
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) begin
        pa_en_out <= 1'b1;
        pa_new_a  <= reduce(sin);
      end
    end
  end

  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (pa_en === 1'b1 && mon_prev !== 1'b1) pulses.push_back(cyc);
    mon_prev = pa_en;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pa_en"}, 64'(pa_en), 0);
    chk({tag, "_res_valid"}, 64'(res_valid), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_res_id"}, 64'(res_id), 0);
    chk({tag, "_res_err"}, 64'(res_err), 0);
    chk({tag, "_ready"}, 64'({req1_ready, req0_ready}), 0);
    chk({tag, "_res_data0"}, 64'(res_data === '0), 1);
    chk({tag, "_pa_a0"}, 64'(pa_a === '0), 1);
  endtask

  task automatic run_job(input bit v0, input bit v1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input int n0, input int n1, input int hold);
    int w, n, t, acc_cyc;
    logic [AW-1:0]   a;
    logic [SIZE-1:0] expd;
    w = (v0 && v1) ? (m_last == 0 ? 1 : 0) : (v1 ? 1 : 0);
    a = w ? a1 : a0;
    n = w ? n1 : n0;
    expd = expect_res(a, n);
    @(negedge clk);
    pulses.delete();
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req1_a = a1;
    req0_rounds = RW'(n0); req1_rounds = RW'(n1);
    #1;
    chk("grant", 64'({req1_ready, req0_ready}), (w ? 64'd2 : 64'd1));
    acc_cyc = cyc;
    m_last = w;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    t = 0;
    while (res_valid !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("res_wait_bound", 64'(t < 2000), 1);
    chk("latency", 64'(cyc - acc_cyc), 64'(7 * n + 1));
    chk("pulse_count", 64'(pulses.size()), 64'(n));
    if (pulses.size() > 0) chk("first_pulse", 64'(pulses[0] - acc_cyc), 1);
    for (int i = 1; i < pulses.size(); i++) chk("pulse_gap", 64'(pulses[i] - pulses[i-1]), 7);
    chk("res_id", 64'(res_id), 64'(w));
    chk("res_err", 64'(res_err), 0);
    chk("res_data", 64'(res_data === expd), 1);
    if (n > 0) chk("congruent", 64'(congruent(res_data, a, n)), 1);
    else       chk("passthru", 64'(res_data === a[SIZE-1:0]), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("hold_ready", 64'({req1_ready, req0_ready}), 0);
      chk("hold_valid", 64'(res_valid), 1);
      chk("hold_data", 64'(res_data === expd), 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("released_valid", 64'(res_valid), 0);
    chk("released_busy", 64'(busy), 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    int t, v, n;
    m = '0;
    for (int i = 0; i < SIZE - 2; i++) m[i] = 1'($urandom_range(0, 1));
    m[SIZE-2] = 1'b1;
    m[0] = 1'b1;
    minv = m[RADIX-1:0];
    for (int i = 0; i < 7; i++) minv = minv * (RADIX'(2) - m[RADIX-1:0] * minv);

    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req1_a = '0; req0_rounds = '0; req1_rounds = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Contention straight after reset: req0 first, then alternating.
    run_job(1, 1, rand_a(), rand_a(), 1, 2, 0);
    run_job(1, 1, rand_a(), rand_a(), 2, 1, 0);
    run_job(1, 1, rand_a(), rand_a(), 0, 1, 0);
    run_job(1, 0, rand_a(), rand_a(), 3, 0, 0);
    run_job(1, 0, rand_a(), rand_a(), 0, 0, 0);
    run_job(0, 1, rand_a(), rand_a(), 0, 2, 20);

    for (int k = 0; k < 8; k++) begin
      v = $urandom_range(1, 3);
      n = $urandom_range(0, 3);
      run_job(v[0], v[1], rand_a(), rand_a(), n, 3 - n, $urandom_range(0, 3));
    end

    // Reset while waiting on the second round.
    @(negedge clk);
    pulses.delete();
    a = rand_a();
    req0_valid = 1'b1; req0_a = a; req0_rounds = RW'(3);
    @(negedge clk);
    req0_valid = 1'b0;
    t = 0;
    while (pulses.size() < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_wait_bound", 64'(t < 200), 1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(busy), 1);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1;
    repeat (LPA + 2) @(negedge clk);
    chk("after_rst_quiet", 64'({busy, res_valid, pa_en}), 0);
    run_job(1, 1, rand_a(), rand_a(), 2, 3, 0);

`ifdef PHASE_A_SCHED_TIMEOUT_EN
    stub_dead = 1'b1;
    @(negedge clk);
    pulses.delete();
    a = rand_a();
    req1_valid = 1'b1; req1_a = a; req1_rounds = RW'(2);
    @(negedge clk);
    req1_valid = 1'b0;
    t = 0;
    while (res_valid !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("to_wait_bound", 64'(t < 500), 1);
    chk("to_pulses", 64'(pulses.size()), 1);
    if (pulses.size() > 0) chk("to_latency", 64'(cyc - pulses[0]), 64'(TIMEOUT + 1));
    chk("to_err", 64'(res_err), 1);
    chk("to_id", 64'(res_id), 1);
    chk("to_data", 64'(res_data === a[SIZE-1:0]), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    stub_dead = 1'b0;
    m_last = 1;
    run_job(1, 0, rand_a(), rand_a(), 1, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
